// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared widths, ALU op encodings and request record for alu_arbiter
package alu_arbiter_pkg;
   localparam int XLEN = 32;
   localparam int ALUOPS = 4;
   localparam logic [ALUOPS-1:0] OP_ADD  = 4'd0;
   localparam logic [ALUOPS-1:0] OP_SUB  = 4'd1;
   localparam logic [ALUOPS-1:0] OP_SLL  = 4'd2;
   localparam logic [ALUOPS-1:0] OP_SLT  = 4'd3;
   localparam logic [ALUOPS-1:0] OP_SLTU = 4'd4;
   localparam logic [ALUOPS-1:0] OP_XOR  = 4'd5;
   localparam logic [ALUOPS-1:0] OP_SRL  = 4'd6;
   localparam logic [ALUOPS-1:0] OP_SRA  = 4'd7;
   localparam logic [ALUOPS-1:0] OP_OR   = 4'd8;
   localparam logic [ALUOPS-1:0] OP_AND  = 4'd9;
   localparam logic [ALUOPS-1:0] OP_EQ   = 4'd10;
   localparam logic [ALUOPS-1:0] OP_NEQ  = 4'd11;
   localparam logic [ALUOPS-1:0] OP_GE   = 4'd12;
   localparam logic [ALUOPS-1:0] OP_GEU  = 4'd13;
   typedef struct packed {
      logic [ALUOPS-1:0] op;
      logic [XLEN-1:0]   a;
      logic [XLEN-1:0]   b;
      logic              port;
   } alu_req_t;
   function automatic logic op_supported(input logic [ALUOPS-1:0] op);
      return op <= OP_GEU;
   endfunction
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu: combinational integer ALU (op, a, b -> y); unknown ops yield 0
module alu
   import alu_arbiter_pkg::*;
(
   input  logic [ALUOPS-1:0] op,
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   output logic [XLEN-1:0]   y
);
   logic [4:0] sh;
   assign sh = b[4:0];
   always_comb begin
      y = '0;
      case (op)
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_SLL:  y = a << sh;
         OP_SLT:  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU: y = {{(XLEN-1){1'b0}}, a < b};
         OP_XOR:  y = a ^ b;
         OP_SRL:  y = a >> sh;
         OP_SRA:  y = $signed(a) >>> sh;
         OP_OR:   y = a | b;
         OP_AND:  y = a & b;
         OP_EQ:   y = {{(XLEN-1){1'b0}}, a == b};
         OP_NEQ:  y = {{(XLEN-1){1'b0}}, a != b};
         OP_GE:   y = {{(XLEN-1){1'b0}}, $signed(a) >= $signed(b)};
         OP_GEU:  y = {{(XLEN-1){1'b0}}, a >= b};
         default: y = '0;
      endcase
   end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between execute (port 0) and branch (port 1) requesters
// Ports: i_clk/i_rst (sync active-high), i_req_valid/o_req_ready + op/a/b per port,
// o_rsp_valid/i_rsp_ready per port, shared o_rsp_data/o_rsp_err, o_busy.
// Build option: define ALU_ARB_RR_EN for round-robin contention, else port 0 has priority.
module alu_arbiter
   import alu_arbiter_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [1:0]        i_req_valid,
   input  logic [ALUOPS-1:0] i_req_op0,
   input  logic [ALUOPS-1:0] i_req_op1,
   input  logic [XLEN-1:0]   i_req_a0,
   input  logic [XLEN-1:0]   i_req_b0,
   input  logic [XLEN-1:0]   i_req_a1,
   input  logic [XLEN-1:0]   i_req_b1,
   output logic [1:0]        o_req_ready,
   output logic [1:0]        o_rsp_valid,
   output logic [XLEN-1:0]   o_rsp_data,
   output logic              o_rsp_err,
   input  logic [1:0]        i_rsp_ready,
   output logic              o_busy
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;
   logic [1:0]      state, state_nx;
   logic [1:0]      grant;
   logic            hs;
   alu_req_t        req;
   logic [XLEN-1:0] alu_y;
`ifdef ALU_ARB_RR_EN
   logic rr_ptr;
   // rr_ptr names the port preferred on the next contention: the one not granted last
   assign grant = &i_req_valid ? (rr_ptr ? 2'b10 : 2'b01) : i_req_valid;
   always_ff @(posedge i_clk)
      if (i_rst) rr_ptr <= 1'b0;
      else if (hs) rr_ptr <= ~grant[1];
`else
   assign grant = i_req_valid[0] ? 2'b01 : i_req_valid & 2'b10;
`endif
   assign hs = state == IDLE && |i_req_valid;
   always_ff @(posedge i_clk)
      if (i_rst) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state == IDLE ? (hs ? EXEC : IDLE) :
                 state == EXEC ? RESP :
                 state == RESP && !i_rsp_ready[req.port] ? RESP : IDLE;
   end
   always_comb begin
      o_req_ready = state == IDLE ? grant : 2'b00;
      o_rsp_valid = state == RESP ? (req.port ? 2'b10 : 2'b01) : 2'b00;
      o_busy      = state != IDLE;
   end
   always_ff @(posedge i_clk)
      if (i_rst) begin
         req        <= '0;
         o_rsp_data <= '0;
         o_rsp_err  <= 1'b0;
      end else begin
         if (hs) req <= grant[1] ? {i_req_op1, i_req_a1, i_req_b1, 1'b1}
                                 : {i_req_op0, i_req_a0, i_req_b0, 1'b0};
         if (state == EXEC) begin
            o_rsp_data <= op_supported(req.op) ? alu_y : '0;
            o_rsp_err  <= !op_supported(req.op);
         end
      end
   alu u_alu (
      .op(req.op),
      .a (req.a),
      .b (req.b),
      .y (alu_y)
   );
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table vectors, corner sequences and random traffic against a reference model
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;
   logic        clk = 0;
   logic        rst = 1;
   logic [1:0]  req_valid = 0, rsp_ready = 0;
   logic [3:0]  op0 = 0, op1 = 0;
   logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
   logic [1:0]  req_ready, rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err, busy;
   int          n_cmp = 0, n_bad = 0;
   int          prefer = 0;
   typedef struct {
      logic        p;
      logic [3:0]  op;
      logic [31:0] a, b, d;
      logic        e;
   } vec_t;
   vec_t tbl[16];

   alu_arbiter dut (
      .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid),
      .i_req_op0(op0), .i_req_op1(op1),
      .i_req_a0(a0), .i_req_b0(b0), .i_req_a1(a1), .i_req_b1(b1),
      .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
      .o_rsp_err(rsp_err), .i_rsp_ready(rsp_ready), .o_busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic int win(input logic [1:0] v);
`ifdef ALU_ARB_RR_EN
      return v == 2'b11 ? prefer : (v[1] ? 1 : 0);
`else
      return v[0] ? 0 : 1;
`endif
   endfunction

   function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int          s;
      logic [31:0] r;
      logic        e;
      s = int'(b % 32);
      r = 0;
      e = 0;
      case (op)
         0:  r = a + b;
         1:  r = a - b;
         2:  r = a << s;
         3:  r = (int'(a) < int'(b)) ? 1 : 0;
         4:  r = (a < b) ? 1 : 0;
         5:  r = a ^ b;
         6:  r = a >> s;
         7:  r = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
         8:  r = a | b;
         9:  r = a & b;
         10: r = (a == b) ? 1 : 0;
         11: r = (a != b) ? 1 : 0;
         12: r = (int'(a) >= int'(b)) ? 1 : 0;
         13: r = (a >= b) ? 1 : 0;
         default: e = 1;
      endcase
      return {e, r};
   endfunction

   // one full transaction starting and ending at a negedge with the arbiter idle
   task automatic run(input logic [1:0] v, input logic [3:0] o0, input logic [31:0] x0, input logic [31:0] y0,
                      input logic [3:0] o1, input logic [31:0] x1, input logic [31:0] y1,
                      input int hold, input logic [31:0] exp_d, input logic exp_e);
      int         p;
      logic [1:0] pm;
      p  = win(v);
      pm = p == 1 ? 2'b10 : 2'b01;
      req_valid = v; rsp_ready = 0;
      op0 = o0; a0 = x0; b0 = y0; op1 = o1; a1 = x1; b1 = y1;
      #1;
      chk("idle_ready", {30'b0, req_ready}, {30'b0, pm});
      chk("idle_busy", {31'b0, busy}, 0);
      @(negedge clk);
      prefer = 1 - p;
      req_valid = v & ~pm;
      #1;
      chk("exec_valid", {30'b0, rsp_valid}, 0);
      chk("exec_busy", {31'b0, busy}, 1);
      chk("exec_ready", {30'b0, req_ready}, 0);
      @(negedge clk);
      chk("resp_valid", {30'b0, rsp_valid}, {30'b0, pm});
      chk("resp_data", rsp_data, exp_d);
      chk("resp_err", {31'b0, rsp_err}, {31'b0, exp_e});
      for (int k = 0; k < hold; k++) begin
         req_valid = 2'b11;
         rsp_ready = ~pm;
         @(negedge clk);
         chk("hold_valid", {30'b0, rsp_valid}, {30'b0, pm});
         chk("hold_data", rsp_data, exp_d);
         chk("hold_err", {31'b0, rsp_err}, {31'b0, exp_e});
         chk("hold_ready", {30'b0, req_ready}, 0);
      end
      req_valid = v & ~pm;
      rsp_ready = pm;
      @(negedge clk);
      rsp_ready = 0;
      chk("accept_busy", {31'b0, busy}, 0);
      chk("accept_valid", {30'b0, rsp_valid}, 0);
      req_valid = 0;
   endtask

   initial begin
      logic [32:0] r;
      logic [1:0]  v;
      logic [3:0]  ra, rb;
      logic [31:0] xa, ya, xb, yb;
      int          p;
      tbl[0]  = '{0, OP_ADD,  32'hFFFF_FFFF, 32'h1,  32'h0,         0};
      tbl[1]  = '{1, OP_SLT,  32'hFFFF_FFFE, 32'h1,  32'h1,         0};
      tbl[2]  = '{1, OP_SLTU, 32'hFFFF_FFFE, 32'h1,  32'h0,         0};
      tbl[3]  = '{1, OP_GEU,  32'hFFFF_FFFE, 32'h1,  32'h1,         0};
      tbl[4]  = '{0, OP_SRA,  32'h8000_0000, 32'h21, 32'hC000_0000, 0};
      tbl[5]  = '{0, OP_SRL,  32'h8000_0000, 32'h21, 32'h4000_0000, 0};
      tbl[6]  = '{0, 4'd14,   32'h1234_5678, 32'h1,  32'h0,         1};
      tbl[7]  = '{1, 4'd15,   32'h5,         32'h6,  32'h0,         1};
      tbl[8]  = '{0, OP_SLL,  32'h1,         32'h3F, 32'h8000_0000, 0};
      tbl[9]  = '{1, OP_EQ,   32'h5,         32'h5,  32'h1,         0};
      tbl[10] = '{1, OP_NEQ,  32'h5,         32'h5,  32'h0,         0};
      tbl[11] = '{1, OP_GE,   32'hFFFF_FFFF, 32'h0,  32'h0,         0};
      tbl[12] = '{0, OP_SUB,  32'h0,         32'h1,  32'hFFFF_FFFF, 0};
      tbl[13] = '{0, OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0};
      tbl[14] = '{0, OP_OR,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 0};
      tbl[15] = '{1, OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0};
      repeat (2) @(negedge clk);
      rst = 0;
      #1;
      chk("rst_ready", {30'b0, req_ready}, 0);
      chk("rst_valid", {30'b0, rsp_valid}, 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_err", {31'b0, rsp_err}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      for (int i = 0; i < 16; i++)
         run(tbl[i].p ? 2'b10 : 2'b01, tbl[i].op, tbl[i].a, tbl[i].b,
             tbl[i].op, tbl[i].a, tbl[i].b, 0, tbl[i].d, tbl[i].e);
      // contention: both return 7 whichever port wins
      run(2'b11, OP_ADD, 3, 4, OP_SUB, 10, 3, 0, 7, 0);
      run(2'b11, OP_ADD, 3, 4, OP_SUB, 10, 3, 0, 7, 0);
      run(2'b11, OP_ADD, 3, 4, OP_SUB, 10, 3, 0, 7, 0);
      run(2'b10, OP_ADD, 3, 4, OP_SUB, 10, 3, 0, 7, 0);
      // response held back for five cycles while both ports request
      run(2'b01, OP_SRA, 32'h8000_0000, 32'h21, OP_ADD, 0, 0, 5, 32'hC000_0000, 0);
      run(2'b10, OP_ADD, 0, 0, 4'd14, 1, 2, 5, 32'h0, 1);
      // reset during EXEC drops the transaction
      run(2'b01, OP_ADD, 3, 4, OP_ADD, 0, 0, 0, 7, 0);
      req_valid = 2'b01; op0 = OP_ADD; a0 = 5; b0 = 6;
      @(negedge clk);
      req_valid = 0;
      rst = 1;
      @(negedge clk);
      rst = 0;
      prefer = 0;
      #1;
      chk("mid_rst_valid", {30'b0, rsp_valid}, 0);
      chk("mid_rst_data", rsp_data, 0);
      chk("mid_rst_err", {31'b0, rsp_err}, 0);
      chk("mid_rst_busy", {31'b0, busy}, 0);
      chk("mid_rst_ready", {30'b0, req_ready}, 0);
      @(negedge clk);
      chk("mid_rst_valid2", {30'b0, rsp_valid}, 0);
      chk("mid_rst_busy2", {31'b0, busy}, 0);
      for (int i = 0; i < 60; i++) begin
         v  = 2'($urandom_range(1, 3));
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         xa = $urandom; ya = (i % 3 == 0) ? 32'($urandom_range(0, 63)) : $urandom;
         xb = $urandom; yb = (i % 4 == 0) ? xb : $urandom;
         p  = win(v);
         r  = p == 1 ? ref_alu(rb, xb, yb) : ref_alu(ra, xa, ya);
         run(v, ra, xa, ya, rb, xb, yb, $urandom_range(0, 2), r[31:0], r[32]);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
